// File: rtl/run_ctrl_pkg.sv
// Shared types for the run/step/halt sequencer.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } run_state_t;

    // States in which the downstream divider is clocked.
    function automatic logic is_active(input run_state_t s);
        return (s == RUN) || (s == STEP);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
// Latency: count updates on the edge after clr/inc. No backpressure; clr has priority over inc.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] SAT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != SAT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/run_controller.sv
// Run/step/halt sequencer driving the clock divider Enable from a flop; counts enabled cycles.
// Latency: inputs sampled at edge k, new state/Enable visible after edge k.
// No backpressure: Start/StepReq outside IDLE/DONE are simply dropped.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int CYCLE_W    = 32,
    parameter int STEP_LEN   = 2,
    parameter int MAX_CYCLES = 0
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               StepReq,
    input  logic               HaltReq,
    input  logic               Abort,
    output logic               Enable,
    output logic               Running,
    output logic               Done,
    output logic               TimedOut,
    output logic [CYCLE_W-1:0] CycleCount
);

    localparam int                 STEP_W    = $clog2(STEP_LEN + 1);
    localparam logic [STEP_W-1:0]  STEP_LOAD = STEP_W'(STEP_LEN - 1);
    localparam logic [CYCLE_W-1:0] WD_LAST   = (MAX_CYCLES == 0) ? '0 : CYCLE_W'(MAX_CYCLES - 1);

    run_state_t        state;
    run_state_t        state_nxt;
    logic [STEP_W-1:0] step_cnt;
    logic [STEP_W-1:0] step_cnt_nxt;
    logic              timed_out_nxt;
    logic              cnt_clr;
    logic              wd_hit;

    // Enable is high on the final watchdog edge, so MAX_CYCLES enabled cycles in total.
    assign wd_hit = (MAX_CYCLES != 0) && (CycleCount == WD_LAST);

    always_comb begin
        state_nxt     = state;
        step_cnt_nxt  = step_cnt;
        timed_out_nxt = TimedOut;
        cnt_clr       = 1'b0;

        case (state)
            IDLE: begin
                if (Start) begin
                    state_nxt = RUN;
                    cnt_clr   = 1'b1;
                end else if (StepReq) begin
                    state_nxt    = STEP;
                    step_cnt_nxt = STEP_LOAD;
                    cnt_clr      = 1'b1;
                end
            end
            RUN: begin
                if (Abort) begin
                    state_nxt = IDLE;
                end else if (HaltReq) begin
                    state_nxt = DONE;
                end else if (wd_hit) begin
                    state_nxt     = DONE;
                    timed_out_nxt = 1'b1;
                end
            end
            STEP: begin
                if (Abort) begin
                    state_nxt = IDLE;
                end else if (HaltReq) begin
                    state_nxt = DONE;
                end else if (step_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    step_cnt_nxt = step_cnt - 1'b1;
                end
            end
            DONE: begin
                if (Start) begin
                    state_nxt     = RUN;
                    timed_out_nxt = 1'b0;
                    cnt_clr       = 1'b1;
                end else if (StepReq || Abort) begin
                    state_nxt     = IDLE;
                    timed_out_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered alongside the state so Enable never glitches.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            step_cnt <= '0;
            Enable   <= 1'b0;
            Running  <= 1'b0;
            Done     <= 1'b0;
            TimedOut <= 1'b0;
        end else begin
            state    <= state_nxt;
            step_cnt <= step_cnt_nxt;
            Enable   <= is_active(state_nxt);
            Running  <= is_active(state_nxt);
            Done     <= (state_nxt == DONE);
            TimedOut <= timed_out_nxt;
        end
    end

    sat_counter #(
        .W(CYCLE_W)
    ) u_cycle_cnt (
        .clk   (Clk),
        .rst   (Reset),
        .clr   (cnt_clr),
        .inc   (Enable),
        .count (CycleCount)
    );

endmodule
